// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory arbiter slice.
package lc3_mem_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    // Requester indices; also the encoding of owner/last_gnt registers.
    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_DMA = 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Requester-side memory handshake: held req, one-cycle ack with read data.
interface lc3_mem_arbiter_if;
    import lc3_mem_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/lc3_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       winner_o
);

    always_comb begin
        winner_o = 1'b0;
        case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~last_gnt_i;
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one synchronous memory between the CPU MAR/MDR path and a DMA port,
// one transaction at a time with a one-cycle strobe and fixed read latency.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    lc3_mem_arbiter_if.slave  cpu_if,
    lc3_mem_arbiter_if.slave  dma_if,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        gnt_o,
    output logic              busy_o
);

    localparam logic [2:0] LatInit = 3'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              winner;

    rr_arb2 u_rr_arb2 (
        .req_i      ({dma_if.req, cpu_if.req}),
        .last_gnt_i (last_gnt_q),
        .winner_o   (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (cpu_if.req || dma_if.req) begin
                    owner_d  = winner;
                    we_d     = winner ? dma_if.we    : cpu_if.we;
                    addr_d   = winner ? dma_if.addr  : cpu_if.addr;
                    wdata_d  = winner ? dma_if.wdata : cpu_if.wdata;
                    // Strobes are registered, so they are set up here for the ISSUE cycle.
                    mem_en_d = 1'b1;
                    mem_we_d = winner ? dma_if.we : cpu_if.we;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (we_q) begin
                    cpu_ack_d = ~owner_q;
                    dma_ack_d = owner_q;
                    state_d   = ARB_RESP;
                end else begin
                    cnt_d   = LatInit;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (owner_q) begin
                        dma_rdata_d = mem_rdata_i;
                    end else begin
                        cpu_rdata_d = mem_rdata_i;
                    end
                    cpu_ack_d = ~owner_q;
                    dma_ack_d = owner_q;
                    state_d   = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ARB_RESP: begin
                last_gnt_d = owner_q;
                state_d    = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_IDLE;
            owner_q     <= 1'b0;
            last_gnt_q  <= 1'(REQ_DMA);
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= 3'd0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign cpu_if.ack   = cpu_ack_q;
    assign cpu_if.rdata = cpu_rdata_q;
    assign dma_if.ack   = dma_ack_q;
    assign dma_if.rdata = dma_rdata_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign busy_o       = (state_q != ARB_IDLE);
    assign gnt_o        = (state_q == ARB_IDLE) ? 2'b00 : owner_onehot(owner_q);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: three instances (MEM_LAT 2, 1, 7) with delay-line memory models.
module tb_lc3_mem_arbiter;

    typedef struct {
        int          inst;
        bit          port;
        bit          we;
        logic [15:0] rdata;
    } exp_t;

    typedef struct {
        int          inst;
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;

    logic        cpu_req [3];
    logic        cpu_we [3];
    logic [15:0] cpu_addr [3];
    logic [15:0] cpu_wdata [3];
    logic        cpu_ack [3];
    logic [15:0] cpu_rdata [3];
    logic        dma_req [3];
    logic        dma_we [3];
    logic [15:0] dma_addr [3];
    logic [15:0] dma_wdata [3];
    logic        dma_ack [3];
    logic [15:0] dma_rdata [3];
    logic        mem_en [3];
    logic        mem_we [3];
    logic [15:0] mem_addr [3];
    logic [15:0] mem_wdata [3];
    logic [15:0] mem_rdata [3];
    logic [1:0]  gnt [3];
    logic        busy [3];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned Lat = (g == 0) ? 2 : (g == 1) ? 1 : 7;

        lc3_mem_arbiter_if cpu_bus ();
        lc3_mem_arbiter_if dma_bus ();

        logic [15:0] mem [65536];
        logic [15:0] rd_pipe [Lat];

        assign cpu_bus.req   = cpu_req[g];
        assign cpu_bus.we    = cpu_we[g];
        assign cpu_bus.addr  = cpu_addr[g];
        assign cpu_bus.wdata = cpu_wdata[g];
        assign cpu_ack[g]    = cpu_bus.ack;
        assign cpu_rdata[g]  = cpu_bus.rdata;
        assign dma_bus.req   = dma_req[g];
        assign dma_bus.we    = dma_we[g];
        assign dma_bus.addr  = dma_addr[g];
        assign dma_bus.wdata = dma_wdata[g];
        assign dma_ack[g]    = dma_bus.ack;
        assign dma_rdata[g]  = dma_bus.rdata;

        lc3_mem_arbiter #(.MEM_LAT(Lat)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .cpu_if      (cpu_bus),
            .dma_if      (dma_bus),
            .mem_en_o    (mem_en[g]),
            .mem_we_o    (mem_we[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g]),
            .gnt_o       (gnt[g]),
            .busy_o      (busy[g])
        );

        // Read data is only valid in the single cycle Lat cycles after the strobe.
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
            rd_pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 16'hDEAD;
            for (int k = 1; k < Lat; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign mem_rdata[g] = rd_pipe[Lat-1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input int inst, input bit port, output int n, output int ec,
                            output logic [15:0] ea, output logic ewe, output logic [15:0] ewd);
        bit seen;
        n    = 0;
        ec   = 0;
        ea   = 16'h0;
        ewe  = 1'b0;
        ewd  = 16'h0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (mem_en[inst]) begin
                ec++;
                ea  = mem_addr[inst];
                ewe = mem_we[inst];
                ewd = mem_wdata[inst];
            end
            seen = port ? dma_ack[inst] : cpu_ack[inst];
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: inst %0d port %0d got no ack, expected one within 30", inst, port);
            n = -1;
        end
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (cpu_ack[i] || dma_ack[i]) begin
                check("ack_exclusive", 32'(cpu_ack[i] && dma_ack[i]), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_inst", 32'(i), 32'(e.inst));
                    check("sb_port", 32'(dma_ack[i]), 32'(e.port));
                    if (!e.we) check("sb_rdata", dma_ack[i] ? dma_rdata[i] : cpu_rdata[i], e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ec;
        logic [15:0] ea, ewd;
        logic ewe;

        vecs[0] = '{0, 1'b0, 1'b1, 16'h3000, 16'h1234, 16'h0000, 2};
        vecs[1] = '{0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 4};
        vecs[2] = '{0, 1'b1, 1'b1, 16'h3002, 16'h5A5A, 16'h0000, 2};
        vecs[3] = '{0, 1'b1, 1'b0, 16'h3002, 16'h0000, 16'h5A5A, 4};
        vecs[4] = '{1, 1'b0, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 2};
        vecs[5] = '{1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 3};
        vecs[6] = '{2, 1'b1, 1'b1, 16'h0200, 16'hC0DE, 16'h0000, 2};
        vecs[7] = '{2, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'hC0DE, 9};
        vecs[8] = '{2, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hC0DE, 9};

        for (int i = 0; i < 3; i++) begin
            cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            dma_req[i] = 1'b0; dma_we[i] = 1'b0; dma_addr[i] = '0; dma_wdata[i] = '0;
        end

        // Reset held with both ports requesting writes.
        rst_n = 1'b0;
        cpu_we[0] = 1'b1; cpu_addr[0] = 16'h0010; cpu_wdata[0] = 16'h1111; cpu_req[0] = 1'b1;
        dma_we[0] = 1'b1; dma_addr[0] = 16'h0020; dma_wdata[0] = 16'h2222; dma_req[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_en", 32'(mem_en[0]), 32'd0);
        check("rst_mem_we", 32'(mem_we[0]), 32'd0);
        check("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata[0]), 32'd0);
        check("rst_gnt", 32'(gnt[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_acks", 32'({cpu_ack[0], dma_ack[0]}), 32'd0);
        check("rst_rdata", 32'({cpu_rdata[0], dma_rdata[0]}), 32'd0);
        sb.push_back('{0, 1'b0, 1'b1, 16'h0});
        sb.push_back('{0, 1'b1, 1'b1, 16'h0});
        rst_n = 1'b1;
        @(negedge clk);
        check("first_gnt_cpu", 32'(gnt[0]), 32'b01);
        check("first_issue_en", 32'(mem_en[0]), 32'd1);
        wait_ack(0, 1'b0, n, ec, ea, ewe, ewd);
        check("first_cpu_ack_lat", 32'(n), 32'd1);
        cpu_req[0] = 1'b0;
        wait_ack(0, 1'b1, n, ec, ea, ewe, ewd);
        check("loser_dma_lat", 32'(n), 32'd3);
        dma_req[0] = 1'b0;

        // Table of single-requester transactions across the three latencies.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            sb.push_back('{vecs[k].inst, vecs[k].port, vecs[k].we, vecs[k].rdata});
            if (vecs[k].port) begin
                dma_we[vecs[k].inst]    = vecs[k].we;
                dma_addr[vecs[k].inst]  = vecs[k].addr;
                dma_wdata[vecs[k].inst] = vecs[k].wdata;
                dma_req[vecs[k].inst]   = 1'b1;
            end else begin
                cpu_we[vecs[k].inst]    = vecs[k].we;
                cpu_addr[vecs[k].inst]  = vecs[k].addr;
                cpu_wdata[vecs[k].inst] = vecs[k].wdata;
                cpu_req[vecs[k].inst]   = 1'b1;
            end
            wait_ack(vecs[k].inst, vecs[k].port, n, ec, ea, ewe, ewd);
            cpu_req[vecs[k].inst] = 1'b0;
            dma_req[vecs[k].inst] = 1'b0;
            check($sformatf("v%0d_lat", k), 32'(n), 32'(vecs[k].lat));
            check($sformatf("v%0d_en_cycles", k), 32'(ec), 32'd1);
            check($sformatf("v%0d_en_addr", k), 32'(ea), 32'(vecs[k].addr));
            check($sformatf("v%0d_en_we", k), 32'(ewe), 32'(vecs[k].we));
            if (vecs[k].we) check($sformatf("v%0d_en_wdata", k), 32'(ewd), 32'(vecs[k].wdata));
            if (k == 3) check("cpu_rdata_hold", 32'(cpu_rdata[0]), 32'h1234);
        end

        // Both ports requesting continuously: strict alternation, one IDLE cycle between.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{0, 1'b0, 1'b1, 16'h0});
            sb.push_back('{0, 1'b1, 1'b1, 16'h0});
        end
        fork
            begin
                int nc, cc;
                logic [15:0] ca, cw;
                logic cwe;
                for (int i = 0; i < 3; i++) begin
                    cpu_we[0] = 1'b1; cpu_addr[0] = 16'h5000 + 16'(i);
                    cpu_wdata[0] = 16'hB000 + 16'(i); cpu_req[0] = 1'b1;
                    wait_ack(0, 1'b0, nc, cc, ca, cwe, cw);
                    check($sformatf("rr_cpu%0d_lat", i), 32'(nc), (i == 0) ? 32'd2 : 32'd6);
                end
                cpu_req[0] = 1'b0;
            end
            begin
                int nd, dc;
                logic [15:0] da, dw;
                logic dwe;
                for (int i = 0; i < 3; i++) begin
                    dma_we[0] = 1'b1; dma_addr[0] = 16'h4000 + 16'(i);
                    dma_wdata[0] = 16'hA000 + 16'(i); dma_req[0] = 1'b1;
                    wait_ack(0, 1'b1, nd, dc, da, dwe, dw);
                    check($sformatf("rr_dma%0d_lat", i), 32'(nd), (i == 0) ? 32'd5 : 32'd6);
                end
                dma_req[0] = 1'b0;
            end
        join
        check("mem_4000", 32'(g_inst[0].mem[16'h4000]), 32'hA000);
        check("mem_4001", 32'(g_inst[0].mem[16'h4001]), 32'hA001);
        check("mem_4002", 32'(g_inst[0].mem[16'h4002]), 32'hA002);
        check("mem_5002", 32'(g_inst[0].mem[16'h5002]), 32'hB002);

        // Reset in the middle of a DMA read, then a clean retry.
        @(negedge clk);
        dma_we[0] = 1'b0; dma_addr[0] = 16'h4001; dma_req[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("midwait_busy", 32'(busy[0]), 32'd1);
        check("midwait_gnt", 32'(gnt[0]), 32'b10);
        #1 rst_n = 1'b0;
        #1;
        check("abort_mem_en", 32'(mem_en[0]), 32'd0);
        check("abort_gnt", 32'(gnt[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_dma_ack", 32'(dma_ack[0]), 32'd0);
        check("abort_mem_addr", 32'(mem_addr[0]), 32'd0);
        check("abort_dma_rdata", 32'(dma_rdata[0]), 32'd0);
        sb.push_back('{0, 1'b1, 1'b0, 16'hA001});
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(0, 1'b1, n, ec, ea, ewe, ewd);
        dma_req[0] = 1'b0;
        check("retry_lat", 32'(n), 32'd4);
        check("retry_en_cycles", 32'(ec), 32'd1);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Two-port memory arbiter and sequencer that shares the LC-3 system's single synchronous memory between the CPU core's MAR/MDR path and a DMA/program-loader port. Each requester issues a held request and receives a one-cycle acknowledge. The arbiter grants round-robin, drives the memory strobes for exactly one cycle per transaction, and waits out the configurable read latency. It sits between the core's memory interface and the memory model/macro.

## Interface
- MEM_LAT, 2, memory read latency in cycles (legal 1..7)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req
- cpu_addr  in  16  address; stable while cpu_req
- cpu_wdata  in  16  write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid when cpu_ack
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same as cpu_* for the DMA port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid MEM_LAT cycles after the mem_en cycle
- gnt  out  2  one-hot current owner (bit0 CPU, bit1 DMA), 00 when idle
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high at the clock edge, select the winner, latch its we/addr/wdata, set gnt, and go to ISSUE. Otherwise stay in IDLE.
- Selection:
  - Single requester: it wins.
  - Both requesting: the port not granted last wins.
  - last_gnt resets to DMA, so the CPU wins the first tie.
- ISSUE: mem_en=1 and mem_we=latched we. Next state is RESP for a write, WAIT for a read.
- WAIT: lasts exactly MEM_LAT cycles, counted by a 3-bit counter. mem_rdata is sampled into the read register at the edge ending the last WAIT cycle.
- RESP: pulse the winner's ack for one cycle. rdata outputs the registered read value; it holds its value until that port's next read completes. Then go to IDLE, clear gnt, and update last_gnt.
- mem_addr and mem_wdata are driven from the latched registers and stay stable from ISSUE through RESP.
- The loser's req stays pending and is serviced after the following IDLE cycle. No request is ever dropped.
- A requester drops or reissues req at the edge ending RESP. Requests are sampled only in IDLE.
- A req deasserted mid-transaction is a protocol violation. The transaction still completes and ack still pulses.
- Both acks are never high in the same cycle.
- Reset (asserted at any time, including mid-transaction):
  - State goes to IDLE immediately.
  - mem_en, mem_we, acks, gnt and busy go to 0.
  - mem_addr, mem_wdata and both rdata registers go to 0.
  - last_gnt goes to DMA.
  - The aborted transaction is never acknowledged.

## Timing
- Edge E0 = the IDLE edge where a req is sampled.
- Write: ISSUE occupies cycle 1 after E0 and ack occurs in cycle 2.
- Read: ISSUE in cycle 1, WAIT in cycles 2..1+MEM_LAT, ack in cycle 2+MEM_LAT.
- Default read latency is 4 cycles to ack.
- Back-to-back transactions are separated by exactly one IDLE cycle.
  - Write throughput: one per 3 cycles.
  - Read throughput: one per 3+MEM_LAT cycles.
- All outputs are registered except gnt and busy, which decode the state and owner registers.

## Structure
- Package lc3_mem_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}
  - REQ_CPU=0 and REQ_DMA=1
  - ADDR_W=16 and DATA_W=16
- One sub-module, rr_arb2: 2-way round-robin picker with inputs req[1:0] and last_gnt, output winner. Purely combinational.
- last_gnt, the FSM, the latency counter and the data registers stay in lc3_mem_arbiter.

## Test plan
- Reset: hold rst=0 with both reqs high.
  - All outputs 0, gnt=00, busy=0, no mem_en.
  - After release, the first grant goes to CPU.
- CPU write 0x3000 <- 0x1234 alone:
  - One cycle with mem_en=mem_we=1, mem_addr=0x3000, mem_wdata=0x1234.
  - cpu_ack in cycle 2 after E0; dma_ack stays 0.
- CPU read 0x3000 with MEM_LAT=2 after the write above:
  - mem_we=0.
  - cpu_ack in cycle 4 with cpu_rdata=0x1234.
- Both ports request continuously, 3 transactions each (DMA writes 0x4000+i <- 0xA000+i):
  - Grant order CPU, DMA, CPU, DMA, CPU, DMA.
  - Never two acks in one cycle.
  - Memory holds 0xA000..0xA002.
- Assert rst mid-WAIT of a DMA read:
  - mem_en, gnt and busy go to 0 before the next edge; no dma_ack.
  - After release with dma_req still high, a fresh read completes with correct data.
- Parameter sweep MEM_LAT=1 and MEM_LAT=7:
  - Read ack lands in cycle 3 and cycle 9 respectively.
  - rdata matches the memory model.
